dma_xfer_sequencer: RTL

- Sequences the 2940-style DMA address generator from a single start command. Drives its 3-bit instruction bus and its data-in bus to load the control register, address and word count, then issues ENABLE COUNTER once per accepted peripheral beat.
- Handles single-pass and auto-repeat (reinitialize) transfers, an ack timeout, and a word-count cross-check against the generator's done flag.
- Sits between the host configuration registers and the address generator.

---
 rtl/dma_xfer_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dma_xfer_sequencer.sv
// Drives a 2940-style DMA address generator from a single start command:
// loads control, address and word count, then issues one ENCT per accepted beat.
module dma_xfer_sequencer #(
    parameter int W       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [2:0]   cfg_ctrl,
    input  logic [W-1:0] cfg_addr,
    input  logic [W-1:0] cfg_count,
    input  logic         cfg_repeat,
    input  logic         wc_done,
    input  logic         xfer_ack,
    output logic [2:0]   instr,
    output logic [W-1:0] gen_data,
    output logic         gen_data_oe,
    output logic         xfer_req,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_CR,
        S_LD_AR,
        S_LD_WC,
        S_XFER,
        S_REINIT,
        S_ERR
    } state_t;

    localparam logic [2:0]   I_WRCR   = 3'b000;
    localparam logic [2:0]   I_RDAR   = 3'b011;
    localparam logic [2:0]   I_REINIT = 3'b100;
    localparam logic [2:0]   I_LDAR   = 3'b101;
    localparam logic [2:0]   I_LDWC   = 3'b110;
    localparam logic [2:0]   I_ENCT   = 3'b111;
    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [15:0]  TMO      = 16'(TIMEOUT);

    state_t         state_q, state_d;
    logic [2:0]     ctrl_q, ctrl_d;
    logic [W-1:0]   addr_q, addr_d;
    logic [W-1:0]   count_q, count_d;
    logic           repeat_q, repeat_d;
    logic [W-1:0]   beats_q, beats_d;
    logic [15:0]    timer_q, timer_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            repeat_q <= 1'b0;
            beats_q  <= '0;
            timer_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            repeat_q <= repeat_d;
            beats_q  <= beats_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        addr_d      = addr_q;
        count_d     = count_q;
        repeat_d    = repeat_q;
        beats_d     = beats_q;
        timer_d     = timer_q;
        done_d      = 1'b0;
        err_d       = err_q;
        instr       = I_RDAR;
        gen_data    = '0;
        gen_data_oe = 1'b0;
        xfer_req    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_count != '0) begin
                        ctrl_d   = cfg_ctrl;
                        addr_d   = cfg_addr;
                        count_d  = cfg_count;
                        repeat_d = cfg_repeat;
                        err_d    = 1'b0;
                        state_d  = S_LD_CR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LD_CR: begin
                instr       = I_WRCR;
                gen_data    = W'(ctrl_q);
                gen_data_oe = 1'b1;
                state_d     = S_LD_AR;
            end
            S_LD_AR: begin
                instr       = I_LDAR;
                gen_data    = addr_q;
                gen_data_oe = 1'b1;
                state_d     = S_LD_WC;
            end
            S_LD_WC: begin
                instr       = I_LDWC;
                gen_data    = count_q;
                gen_data_oe = 1'b1;
                beats_d     = count_q;
                timer_d     = '0;
                state_d     = S_XFER;
            end
            S_XFER: begin
                xfer_req = 1'b1;
                if (xfer_ack) begin
                    instr = I_ENCT;
                end
                // Generator claiming completion while beats remain means the two counts disagree.
                if (wc_done && (beats_q > ONE)) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else if (xfer_ack) begin
                    beats_d = beats_q - ONE;
                    timer_d = '0;
                    if (beats_q == ONE) begin
                        done_d  = 1'b1;
                        state_d = repeat_q ? S_REINIT : S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                    if (timer_d == TMO) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_REINIT: begin
                instr   = I_REINIT;
                beats_d = count_q;
                timer_d = '0;
                state_d = S_XFER;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything except reporting a beat the peripheral already took.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            done_d      = 1'b0;
            err_d       = err_q;
            xfer_req    = 1'b0;
            gen_data    = '0;
            gen_data_oe = 1'b0;
            instr       = ((state_q == S_XFER) && xfer_ack) ? I_ENCT : I_RDAR;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule
